// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
// Opcode values match the Sel0/Sel1 encoding forwarded untouched on Alu_Select.
package alu_sched_pkg;

  localparam int DATA_W = 4;
  localparam int RES_W  = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [1:0]        sel;
  } operand_t;

  function automatic operand_t pick_operands(input logic idx, input operand_t op0,
                                             input operand_t op1);
    return idx ? op1 : op0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
// last = index of the requester granted most recently.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one multi-cycle ALU between two requesters with round-robin arbitration.
// Define ALU_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles with Err=1.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch winner's operands
// LAUNCH | Alu_Init pulse to the ALU
// WAIT   | waiting for Alu_Done (or timeout when enabled)
// RESP   | one-cycle Ack to the granted requester, advance round-robin pointer
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req0,
  input  logic              Req1,
  input  logic [DATA_W-1:0] A0,
  input  logic [DATA_W-1:0] B0,
  input  logic [DATA_W-1:0] A1,
  input  logic [DATA_W-1:0] B1,
  input  logic [1:0]        Sel0,
  input  logic [1:0]        Sel1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [RES_W-1:0]  Result,
  output logic              Carry,
  output logic              Err,
  output logic              Busy,
  output logic [DATA_W-1:0] Alu_A,
  output logic [DATA_W-1:0] Alu_B,
  output logic [1:0]        Alu_Select,
  output logic              Alu_Init,
  input  logic              Alu_Done,
  input  logic [RES_W-1:0]  Alu_Sal,
  input  logic              Alu_Cout
);

  state_t     state;
  logic       last_gnt;
  logic       gnt_idx;
  logic [1:0] grant;
  operand_t   op0;
  operand_t   op1;

  assign op0 = {A0, B0, Sel0};
  assign op1 = {A1, B1, Sel1};

  rr_arbiter2 u_arb (
    .req   ({Req1, Req0}),
    .last  (last_gnt),
    .grant (grant)
  );

`ifdef ALU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= ST_IDLE;
      Ack0       <= 1'b0;
      Ack1       <= 1'b0;
      Alu_Init   <= 1'b0;
      Busy       <= 1'b0;
      Carry      <= 1'b0;
      Result     <= '0;
      Alu_A      <= '0;
      Alu_B      <= '0;
      Alu_Select <= 2'b00;
      last_gnt   <= 1'b1;
      gnt_idx    <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      err_q      <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      Ack0     <= 1'b0;
      Ack1     <= 1'b0;
      Alu_Init <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            gnt_idx <= grant[1];
            {Alu_A, Alu_B, Alu_Select} <= pick_operands(grant[1], op0, op1);
            Alu_Init <= 1'b1;
            Busy     <= 1'b1;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
`ifdef ALU_TIMEOUT_EN
          tmo_cnt <= TMO_LOAD;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (Alu_Done) begin
            Result <= Alu_Sal;
            Carry  <= Alu_Cout;
`ifdef ALU_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            Ack0   <= ~gnt_idx;
            Ack1   <= gnt_idx;
            state  <= ST_RESP;
          end
`ifdef ALU_TIMEOUT_EN
          // Terminal count reached on the TIMEOUT_CYCLES-th WAIT cycle.
          else if (tmo_cnt == '0) begin
            Result <= '0;
            Carry  <= 1'b0;
            err_q  <= 1'b1;
            Ack0   <= ~gnt_idx;
            Ack1   <= gnt_idx;
            state  <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        ST_RESP: begin
          last_gnt <= gnt_idx;
          Busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: a behavioural ALU answers Alu_Init and
// every Ack is matched against the expected queue filled when requests are issued.
module tb_alu_scheduler;

  typedef struct {
    logic       who;
    logic [7:0] res;
    logic       cy;
    logic       err;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Req0, Req1;
  logic [3:0] A0, B0, A1, B1;
  logic [1:0] Sel0, Sel1;
  logic       Ack0, Ack1;
  logic [7:0] Result;
  logic       Carry, Err, Busy;
  logic [3:0] Alu_A, Alu_B;
  logic [1:0] Alu_Select;
  logic       Alu_Init;
  logic       Alu_Done;
  logic [7:0] Alu_Sal;
  logic       Alu_Cout;

  int   issued0 = 0, issued1 = 0, done0 = 0, done1 = 0;
  int   ack_cnt = 0, init_cnt = 0;
  int   n_tests = 0, n_fail = 0;
  int   alu_delay = 0;
  logic alu_hang = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  assign Req0 = (issued0 != done0);
  assign Req1 = (issued1 != done1);

  always #5 Clk = ~Clk;

  alu_scheduler #(.TIMEOUT_CYCLES(4)) dut (
    .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1), .Sel0(Sel0), .Sel1(Sel1),
    .Ack0(Ack0), .Ack1(Ack1), .Result(Result), .Carry(Carry), .Err(Err), .Busy(Busy),
    .Alu_A(Alu_A), .Alu_B(Alu_B), .Alu_Select(Alu_Select), .Alu_Init(Alu_Init),
    .Alu_Done(Alu_Done), .Alu_Sal(Alu_Sal), .Alu_Cout(Alu_Cout)
  );

  // Reference ALU: {carry/borrow, result}
  function automatic logic [8:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] sel);
    logic [4:0] s;
    case (sel)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; return {s[4], 4'h0, s[3:0]}; end
      2'b01: begin s = {1'b0, a} - {1'b0, b}; return {(a < b), 4'h0, s[3:0]}; end
      2'b10: return {1'b0, {4'h0, a} * {4'h0, b}};
      default: return {1'b0, 4'h0, a & b};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic who, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] sel);
    exp_t e;
    logic [8:0] r;
    r = alu_fn(a, b, sel);
    e.who = who; e.res = r[7:0]; e.cy = r[8]; e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n;
    n = 0;
    while (ack_cnt < target && n < budget) begin
      @(negedge Clk); #1;
      n++;
    end
    if (ack_cnt < target) check("ack_timeout", ack_cnt, target);
  endtask

  // Behavioural ALU: Alu_Done pulses alu_delay+1 cycles after Alu_Init
  initial begin
    Alu_Done = 1'b0; Alu_Sal = 8'h00; Alu_Cout = 1'b0;
    forever begin
      @(negedge Clk);
      if (Alu_Init && !alu_hang) begin
        repeat (alu_delay) @(posedge Clk);
        @(posedge Clk); #1;
        {Alu_Cout, Alu_Sal} = alu_fn(Alu_A, Alu_B, Alu_Select);
        Alu_Done = 1'b1;
        @(posedge Clk); #1;
        Alu_Done = 1'b0;
        Alu_Sal  = 8'hEE;
        Alu_Cout = 1'b1;
      end
    end
  end

  always @(negedge Clk) begin
    if (Alu_Init) init_cnt++;
    if (Ack0 || Ack1) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {Ack1, Ack0}, 2'b00);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_sel", {Ack1, Ack0}, mon_e.who ? 2'b10 : 2'b01);
        check("result", Result, mon_e.res);
        check("carry", Carry, mon_e.cy);
        check("err", Err, mon_e.err);
      end
      if (Ack0) done0++;
      if (Ack1) done1++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, ib, d1, lat, low;
    Rst = 1'b1;
    A0 = 4'h0; B0 = 4'h0; A1 = 4'h0; B1 = 4'h0; Sel0 = 2'b00; Sel1 = 2'b00;
    repeat (2) @(negedge Clk);
    check("rst_busy", Busy, 1'b0);
    check("rst_ack", {Ack1, Ack0}, 2'b00);
    check("rst_init", Alu_Init, 1'b0);
    check("rst_result", Result, 8'h00);
    check("rst_carry_err", {Carry, Err}, 2'b00);
    check("rst_alu_ops", {Alu_A, Alu_B, Alu_Select}, 10'h000);
    Rst = 1'b0;

    // Both requesters held from reset: requester 0 first, then strict alternation
    A0 = 4'h7; B0 = 4'h6; Sel0 = 2'b10;
    A1 = 4'hC; B1 = 4'hA; Sel1 = 2'b11;
    push(1'b0, A0, B0, Sel0); push(1'b1, A1, B1, Sel1);
    push(1'b0, A0, B0, Sel0); push(1'b1, A1, B1, Sel1);
    base = ack_cnt; ib = init_cnt;
    issued0 += 2; issued1 += 2;
    wait_acks(base + 4, 60);
    check("alt_inits", init_cnt - ib, 4);

    // Single request, Done in first WAIT cycle: Req-to-Ack is 4 cycles
    @(negedge Clk); #1;
    check("idle_busy", Busy, 1'b0);
    A0 = 4'h3; B0 = 4'h5; Sel0 = 2'b00;
    push(1'b0, A0, B0, Sel0);
    ib = init_cnt; d1 = done1;
    issued0++;
    lat = 1;
    while (!Ack0 && lat < 20) begin
      @(negedge Clk); #1;
      lat++;
    end
    check("req_to_ack", lat, 4);
    repeat (3) @(negedge Clk);
    #1;
    check("single_inits", init_cnt - ib, 1);
    check("no_ack1", done1 - d1, 0);
    check("hold_result", {Result, Carry, Err}, {8'h08, 2'b00});

    // Req1 arrives while Req0 is being served: one IDLE cycle between them
    A0 = 4'hF; B0 = 4'h1; Sel0 = 2'b00;
    alu_delay = 3;
    push(1'b0, A0, B0, Sel0);
    base = ack_cnt;
    issued0++;
    repeat (2) @(negedge Clk);
    #1;
    check("busy_in_wait", Busy, 1'b1);
    A1 = 4'h9; B1 = 4'h3; Sel1 = 2'b01;
    push(1'b1, A1, B1, Sel1);
    issued1++;
    wait_acks(base + 1, 30);
    low = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk); #1;
      if (Busy) break;
      low++;
    end
    check("idle_gap", low, 1);
    wait_acks(base + 2, 30);
    alu_delay = 0;

    // Reset during WAIT abandons the transaction; requester re-presents
    @(negedge Clk); #1;
    alu_hang = 1'b1;
    A0 = 4'h2; B0 = 4'h5; Sel0 = 2'b01;
    base = ack_cnt;
    issued0++;
    repeat (3) @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    check("mid_rst_busy_init", {Busy, Alu_Init}, 2'b00);
    check("mid_rst_ack", {Ack1, Ack0}, 2'b00);
    check("mid_rst_result", {Result, Carry, Err}, 10'h000);
    check("mid_rst_alu_ops", {Alu_A, Alu_B, Alu_Select}, 10'h000);
    @(negedge Clk);
    check("mid_rst_no_ack", ack_cnt, base);
    Rst = 1'b0;
    alu_hang = 1'b0;
    push(1'b0, A0, B0, Sel0);
    wait_acks(base + 1, 30);

    // ALU never answers
    @(negedge Clk); #1;
    alu_hang = 1'b1;
    A0 = 4'h5; B0 = 4'h5; Sel0 = 2'b00;
    base = ack_cnt;
`ifdef ALU_TIMEOUT_EN
    mon_e.who = 1'b0; mon_e.res = 8'h00; mon_e.cy = 1'b0; mon_e.err = 1'b1;
    exp_q.push_back(mon_e);
    issued0++;
    lat = 1;
    while (!Ack0 && lat < 40) begin
      @(negedge Clk); #1;
      lat++;
    end
    check("timeout_lat", lat, 7);
    alu_hang = 1'b0;
`else
    issued0++;
    repeat (40) @(negedge Clk);
    #1;
    check("hang_no_ack", ack_cnt, base);
    check("hang_busy", Busy, 1'b1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    alu_hang = 1'b0;
    push(1'b0, A0, B0, Sel0);
    wait_acks(base + 1, 30);
`endif

    repeat (3) @(negedge Clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32, max ALU cycles in WAIT before abort (used only with ALU_TIMEOUT_EN).
REQ-002 SHALL have port Clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports Req0/Req1  input  1  operation request from requester 0/1, held high until matching Ack.
REQ-005 SHALL have ports A0/A1, B0/B1  input  4  operands of requester 0/1.
REQ-006 SHALL have ports Sel0/Sel1  input  2  operation code (00 add, 01 sub, 10 mul, 11 and).
REQ-007 SHALL have ports Ack0/Ack1  output  1  one-cycle completion strobe to requester 0/1.
REQ-008 SHALL have port Result  output  8  ALU result, valid while an Ack is high.
REQ-009 SHALL have port Carry  output  1  ALU carry/borrow, valid while an Ack is high.
REQ-010 SHALL have port Err  output  1  timeout flag, valid while an Ack is high.
REQ-011 SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have ports Alu_A/Alu_B  output  4, Alu_Select  output  2  latched operands and opcode to the ALU.
REQ-013 SHALL have port Alu_Init  output  1  active-high one-cycle start pulse to the ALU.
REQ-014 SHALL have ports Alu_Done  input  1, Alu_Sal  input  8, Alu_Cout  input  1  ALU completion, result, carry.

Function
REQ-015 SHALL implement FSM IDLE -> LAUNCH -> WAIT -> RESP -> IDLE; all outputs registered.
REQ-016 IDLE: if any Req high, SHALL grant one requester, latch its A/B/Sel into Alu_A/Alu_B/Alu_Select, go to LAUNCH; else stay.
REQ-017 Arbitration SHALL be round-robin: with both Req high, grant the requester not granted last; with one Req high, grant it.
REQ-018 LAUNCH: Alu_Init SHALL be 1 for exactly this one cycle; next state WAIT.
REQ-019 WAIT: on Alu_Done=1 SHALL capture Alu_Sal into Result and Alu_Cout into Carry, Err=0, go to RESP; Alu_Done outside WAIT SHALL be ignored.
REQ-020 RESP: SHALL assert Ack of granted requester only, for one cycle, update last-granted pointer, return to IDLE.
REQ-021 Alu_A/Alu_B/Alu_Select SHALL remain stable from LAUNCH through RESP.
REQ-022 Latency: Req sampled in cycle N -> Alu_Init in N+1 -> Ack one cycle after Alu_Done; minimum Req-to-Ack = 4 cycles when Done arrives first WAIT cycle.
REQ-023 A Req arriving while Busy SHALL wait; it is served in the next IDLE cycle, no request lost.
REQ-024 Result/Carry/Err SHALL hold last values between Acks.

Reset
REQ-025 Rst high SHALL immediately force state IDLE, Ack0=Ack1=0, Alu_Init=0, Busy=0, Err=0, Carry=0, Result=0, Alu_A=Alu_B=0, Alu_Select=00, last-granted=1 (requester 0 wins first tie).
REQ-026 Reset mid-operation SHALL abandon the transaction with no Ack; requester re-presents after reset.

Configuration
REQ-027 With ALU_TIMEOUT_EN defined, a counter SHALL run in WAIT; after TIMEOUT_CYCLES cycles without Alu_Done, go to RESP with Err=1, Result=0, Carry=0; counter cleared on WAIT entry.
REQ-028 Without ALU_TIMEOUT_EN, WAIT SHALL wait indefinitely and Err SHALL be constant 0.

Structure
REQ-029 Package alu_sched_pkg SHALL hold state encoding, opcode constants OP_ADD/OP_SUB/OP_MUL/OP_AND, DATA_W=4, RES_W=8.
REQ-030 Two-way round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs req[1:0], last; output grant[1:0]).

Verification
REQ-031 Req0=1, A0=3, B0=5, Sel0=00, Done 1 cycle after Init, Sal=8'h08 -> one Alu_Init pulse, Ack0 with Result=8'h08, Carry=0, Ack1 never.
REQ-032 Req0 and Req1 both high from reset (Sel0=10 A0=7 B0=6; Sel1=11 A1=C B1=A) -> Ack0 first (Result=8'h2A), then Ack1 (Result=8'h08), strict alternation while both held.
REQ-033 Req1 raised while serving Req0 -> Req1 served immediately after Ack0, no lost request, Busy high throughout except one IDLE cycle.
REQ-034 Rst pulsed during WAIT -> all outputs at reset values same cycle, no Ack; later Req0 completes normally.
REQ-035 ALU_TIMEOUT_EN, TIMEOUT_CYCLES=4, Alu_Done held 0 -> Ack0 with Err=1, Result=0 after 4 WAIT cycles; without macro, no Ack and Busy stays 1.
